// File: rtl/vga_pattern_gen.sv
// Selectable VGA test-pattern source: bars, checkerboard, ramp, solid cycle, moving bar.
// Define PATTERN_AUTO_CYCLE_EN to advance the pattern automatically every AUTO_FRAMES frames.
module vga_pattern_gen #(
  parameter int HSZ         = 10,
  parameter int VSZ         = 9,
  parameter int HRES        = 640,
  parameter int PIX_SZ      = 4,
  parameter int AUTO_FRAMES = 120
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [HSZ-1:0]    hcount_i,
  input  logic [VSZ-1:0]    vcount_i,
  input  logic              de_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              next_i,
  output logic [PIX_SZ-1:0] r_o,
  output logic [PIX_SZ-1:0] g_o,
  output logic [PIX_SZ-1:0] b_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o,
  output logic [2:0]        mode_o
);

  localparam int BAR_W = HRES / 8;
  localparam int CW    = 3 * PIX_SZ;
  localparam logic [PIX_SZ-1:0] MAX = '1;
  localparam logic [PIX_SZ-1:0] ZER = '0;

  logic [2:0]    mode;
  logic          pending;
  logic [7:0]    frame_cnt;
  logic          fs;
  logic          adv_req;
  logic          advance;
  logic [CW-1:0] color_p0;
  logic [CW-1:0] color_p1;
  logic          de_p1, hsync_p1, vsync_p1;
  logic [CW-1:0] color_p2;
  logic          de_p2, hsync_p2, vsync_p2;

  function automatic logic [CW-1:0] bar_color(input logic [HSZ-1:0] h);
    logic [HSZ-1:0] k;
    k = h / HSZ'(BAR_W);
    case (k)
      HSZ'(0):  bar_color = {MAX, MAX, MAX};
      HSZ'(1):  bar_color = {MAX, MAX, ZER};
      HSZ'(2):  bar_color = {ZER, MAX, MAX};
      HSZ'(3):  bar_color = {ZER, MAX, ZER};
      HSZ'(4):  bar_color = {MAX, ZER, MAX};
      HSZ'(5):  bar_color = {MAX, ZER, ZER};
      HSZ'(6):  bar_color = {ZER, ZER, MAX};
      default:  bar_color = {ZER, ZER, ZER};
    endcase
  endfunction

  function automatic logic [CW-1:0] solid_color(input logic [1:0] sel);
    case (sel)
      2'd0:    solid_color = {MAX, ZER, ZER};
      2'd1:    solid_color = {ZER, MAX, ZER};
      2'd2:    solid_color = {ZER, ZER, MAX};
      default: solid_color = {MAX, MAX, MAX};
    endcase
  endfunction

  assign fs = (hcount_i == '0) && (vcount_i == '0);

`ifdef PATTERN_AUTO_CYCLE_EN
  logic [7:0] auto_cnt;
  logic       auto_hit;

  assign auto_hit = (auto_cnt == 8'(AUTO_FRAMES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      auto_cnt <= '0;
    end else if (fs) begin
      auto_cnt <= auto_hit ? 8'd0 : auto_cnt + 8'd1;
    end
  end

  assign adv_req = pending | next_i | auto_hit;
`else
  assign adv_req = pending | next_i;
`endif

  // A request arriving on the FS cycle is taken immediately, so it never lingers as pending.
  assign advance = fs & adv_req;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode      <= 3'd0;
      pending   <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      if (fs) frame_cnt <= frame_cnt + 8'd1;
      if (advance) begin
        mode    <= (mode == 3'd4) ? 3'd0 : mode + 3'd1;
        pending <= 1'b0;
      end else if (next_i) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    color_p0 = '0;
    case (mode)
      3'd0: color_p0 = bar_color(hcount_i);
      3'd1: color_p0 = (hcount_i[5] ^ vcount_i[5]) ? '1 : '0;
      3'd2: color_p0 = {3{hcount_i[PIX_SZ+5:6]}};
      3'd3: color_p0 = solid_color(frame_cnt[7:6]);
      3'd4: color_p0 = (hcount_i[9:4] == frame_cnt[5:0]) ? '1 : '0;
      default: color_p0 = '0;
    endcase
  end

  // Stage 1: pattern colour and timing flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      color_p1 <= '0;
      de_p1    <= 1'b0;
      hsync_p1 <= 1'b0;
      vsync_p1 <= 1'b0;
    end else begin
      color_p1 <= color_p0;
      de_p1    <= de_i;
      hsync_p1 <= hsync_i;
      vsync_p1 <= vsync_i;
    end
  end

  // Stage 2: blanking and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      color_p2 <= '0;
      de_p2    <= 1'b0;
      hsync_p2 <= 1'b0;
      vsync_p2 <= 1'b0;
    end else begin
      color_p2 <= de_p1 ? color_p1 : '0;
      de_p2    <= de_p1;
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;
    end
  end

  assign r_o     = color_p2[CW-1 -: PIX_SZ];
  assign g_o     = color_p2[2*PIX_SZ-1 -: PIX_SZ];
  assign b_o     = color_p2[PIX_SZ-1:0];
  assign de_o    = de_p2;
  assign hsync_o = hsync_p2;
  assign vsync_o = vsync_p2;
  assign mode_o  = mode;

endmodule
